mult_64: RTL and testbench

Sequential unsigned shift-and-add multiplier for the position-computation datapath. It is the inverse companion of the shift/subtract divider: same start/busy handshake, same iterative one-bit-per-cycle structure. It accepts two WIDTH-bit operands and produces the full 2*WIDTH-bit product, plus an overflow flag for consumers that keep only the low half.

---
 rtl/mult_pkg.sv | 17 +
 rtl/mult_datapath.sv | 49 ++++
 rtl/mult_64.sv | 100 ++++++++++
 tb/tb_mult_64.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
// The optional early-exit build is selected with the MULT_EARLY_EXIT_EN macro.
package mult_pkg;

    localparam int MULT_WIDTH_DEFAULT = 64;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    // Counter width able to hold the value WIDTH itself.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_datapath.sv
// Accumulator, shifting multiplicand and multiplier registers for mult_64.
// load seeds a new operation; step performs one add-and-shift iteration.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   acc_sum,
    output logic                 mplier_last
);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    // Sum for the current step; also the final product on the last step.
    always_comb begin
        acc_sum = acc;
        if (mplier[0]) begin
            acc_sum = acc + mcand;
        end
    end

    // True when the multiplier will be zero after this step's shift.
    assign mplier_last = (mplier[WIDTH-1:1] == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
        end else if (step) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/mult_64.sv
// Sequential unsigned multiplier, one multiplier bit per cycle, full 2*WIDTH product.
// Define MULT_EARLY_EXIT_EN to stop as soon as the remaining multiplier bits are zero.
module mult_64
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init_in,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   Result,
    output logic                 ovf,
    output logic                 busy,
    output logic                 done,
    output state_t               state_dbg
);

    // Handshake: init_in is level-sampled only while IDLE (busy low); busy is
    // high for every CALC cycle; done pulses for one cycle as Result/ovf update
    // and is never high together with busy. Requests while busy are dropped.

    localparam int CW = cnt_w(WIDTH);

`ifdef MULT_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    state_t              state, state_next;
    logic [CW-1:0]       cnt, cnt_next;
    logic                load, step, finish;
    logic [2*WIDTH-1:0]  acc_sum;
    logic                mplier_last;

    mult_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .step        (step),
        .a           (A),
        .b           (B),
        .acc_sum     (acc_sum),
        .mplier_last (mplier_last)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (init_in) begin
                    load       = 1'b1;
                    cnt_next   = CW'(WIDTH);
                    state_next = CALC;
                end
            end
            CALC: begin
                step     = 1'b1;
                cnt_next = cnt - CW'(1);
                if ((cnt == CW'(1)) || (EARLY_EXIT && mplier_last)) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            Result <= '0;
            ovf    <= 1'b0;
            done   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            done  <= finish;
            if (finish) begin
                Result <= acc_sum;
                ovf    <= |acc_sum[2*WIDTH-1:WIDTH];
            end
        end
    end

    assign busy      = (state == CALC);
    assign state_dbg = state;

endmodule

// File: tb/tb_mult_64.sv
// Directed bench for mult_64: drivers push expected products and done cycles,
// an independent monitor checks them whenever done pulses.
module tb_mult_64;
    import mult_pkg::*;

    localparam int W = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           init_in = 1'b0;
    logic [W-1:0]   A = '0;
    logic [W-1:0]   B = '0;
    logic [2*W-1:0] Result;
    logic           ovf;
    logic           busy;
    logic           done;
    state_t         state_dbg;

    logic [2*W:0]   exp_q[$];
    int             lat_q[$];
    int             n_cmp = 0;
    int             n_err = 0;
    int             cyc = 0;

    mult_64 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .init_in   (init_in),
        .A         (A),
        .B         (B),
        .Result    (Result),
        .ovf       (ovf),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // clock/reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int exp_lat(input logic [W-1:0] b);
`ifdef MULT_EARLY_EXIT_EN
        int l = 1;
        for (int i = 0; i < W; i++) if (b[i]) l = i + 1;
        return l;
`else
        return W;
`endif
    endfunction

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (busy && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idle: busy still %0b after %0d cycles, required 0", busy, t);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] b, input logic [2*W-1:0] res, input logic exp_ovf);
        exp_q.push_back({exp_ovf, res});
        lat_q.push_back(cyc + exp_lat(b));
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] res, input logic exp_ovf);
        wait_idle();
        A = a;
        B = b;
        init_in = 1'b1;
        @(posedge clk);
        #1;
        init_in = 1'b0;
        push_exp(b, res, exp_ovf);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst && done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required no pulse", cyc);
            end else begin
                logic [2*W:0] e;
                int           ec;
                e  = exp_q.pop_front();
                ec = lat_q.pop_front();
                check("result", Result, e[2*W-1:0]);
                check("ovf", {{(2*W-1){1'b0}}, ovf}, {{(2*W-1){1'b0}}, e[2*W]});
                check("done_cycle", (2*W)'(cyc), (2*W)'(ec));
                check("busy_on_done", {{(2*W-1){1'b0}}, busy}, '0);
            end
        end
    end

    initial begin : stim
        int k;
        int l;
        repeat (2) @(negedge clk);
        check("rst_result", Result, '0);
        check("rst_ovf", {{(2*W-1){1'b0}}, ovf}, '0);
        check("rst_busy", {{(2*W-1){1'b0}}, busy}, '0);
        check("rst_done", {{(2*W-1){1'b0}}, done}, '0);
        rst = 1'b1;

        run_op(64'd3, 64'd5, 128'd15, 1'b0);
        run_op('1, '1, 128'hFFFFFFFFFFFFFFFE_0000000000000001, 1'b1);
        run_op(64'h8000000000000000, 64'd2, 128'h1_0000000000000000, 1'b1);
        run_op(64'hFFFFFFFF, 64'h100000001, 128'hFFFFFFFFFFFFFFFF, 1'b0);

        // request and operand change mid-operation must be ignored
        wait_idle();
        A = 64'd2;
        B = 64'd3;
        init_in = 1'b1;
        @(posedge clk);
        #1;
        init_in = 1'b0;
        push_exp(64'd3, 128'd6, 1'b0);
        l = exp_lat(64'd3);
        k = (l > 20) ? 20 : 1;
        repeat (k - 1) @(posedge clk);
        @(negedge clk);
        A = 64'd9;
        B = 64'd9;
        init_in = 1'b1;
        @(posedge clk);
        #1;
        init_in = 1'b0;
        A = '0;
        B = '0;

        // reset in the middle of an operation discards it
        wait_idle();
        A = 64'd5;
        B = 64'd7;
        init_in = 1'b1;
        @(posedge clk);
        #1;
        init_in = 1'b0;
        l = exp_lat(64'd7);
        k = (l - 1 < 10) ? l - 1 : 10;
        repeat (k - 1) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_result", Result, '0);
        check("midrst_ovf", {{(2*W-1){1'b0}}, ovf}, '0);
        check("midrst_busy", {{(2*W-1){1'b0}}, busy}, '0);
        check("midrst_done", {{(2*W-1){1'b0}}, done}, '0);
        @(negedge clk);
        rst = 1'b1;
        repeat (80) @(negedge clk);

        // init_in held high: back-to-back operations
        wait_idle();
        A = 64'd10;
        B = 64'd10;
        init_in = 1'b1;
        l = exp_lat(64'd10);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            push_exp(64'd10, 128'd100, 1'b0);
            if (i < 2) repeat (l) @(posedge clk);
        end
        init_in = 1'b0;

        run_op(64'd123, 64'd0, 128'd0, 1'b0);
        run_op(64'd123, 64'h10, 128'd1968, 1'b0);
        run_op(64'd0, '1, 128'd0, 1'b0);

        begin
            int t = 0;
            while (exp_q.size() > 0 && t < 300) begin
                @(negedge clk);
                t++;
            end
            repeat (5) @(negedge clk);
            check("drain_pending", (2*W)'(exp_q.size()), '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
